if_fetch: RTL and testbench

Instruction-fetch sequencer between the PC register and the IF/ID boundary. It takes the current PC value and issues one word-aligned instruction read at a time on an SRAM-like request/response bus. It advances the PC only when that address is accepted, and presents each fetched instruction with its PC to decode through a valid/ready register. Branch and exception redirects arrive on `flush`, which kills the fetch in flight and drops its response.

---
 rtl/if_fetch.sv | 147 ++++++++++++++
 tb/tb_if_fetch.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch : instruction-fetch sequencer between the PC register and IF/ID.
//
// Issues one word-aligned read at a time on an SRAM-like req/addr_ok/data_ok
// bus, pulses pc_enable once per accepted address, and presents each fetched
// word with its PC through a valid/ready output register. flush kills the
// fetch in flight (its late response is dropped) and empties the output.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   pc_in             current PC register value
//   pc_enable         PC loads its next value at this edge
//   flush             redirect this cycle
//   inst_req/addr     bus request and address (registered)
//   inst_addr_ok      address accepted this cycle
//   inst_data_ok      read data valid this cycle
//   inst_rdata        read data
//   out_valid/ready   output handshake towards decode
//   out_pc/inst/adel  presented PC, instruction word, misaligned-address flag
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] INST_NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic        pc_enable,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adel
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        inst_req_q, inst_req_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_adel_q, out_adel_d;

  logic issue;
  logic misaligned;
  logic load_fetch;
  logic load_adel;

  // A new fetch may only start when the output register is free (or being
  // drained this cycle), so WAIT never has to stall on a full output.
  assign issue      = (state_q == S_IDLE) && !flush && (!out_valid_q || out_ready);
  assign misaligned = |pc_in[1:0];
  assign load_fetch = (state_q == S_WAIT) && inst_data_ok && !flush;
  assign load_adel  = issue && misaligned;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_pc_q    <= 32'h0;
      inst_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'h0;
      out_inst_q  <= INST_NOP;
      out_adel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_pc_q    <= req_pc_d;
      inst_req_q  <= inst_req_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_adel_q  <= out_adel_d;
    end
  end

  // Next-state logic; flush takes priority in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue && !misaligned) state_d = S_REQ;
      end
      S_REQ: begin
        // An address accepted in the flush cycle still owes a response.
        if (flush)             state_d = inst_addr_ok ? S_DISCARD : S_IDLE;
        else if (inst_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush)             state_d = inst_data_ok ? S_IDLE : S_DISCARD;
        else if (inst_data_ok) state_d = S_IDLE;
      end
      S_DISCARD: begin
        if (inst_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    pc_enable = rst_n && (flush || ((state_q == S_REQ) && inst_addr_ok) || load_adel);

    inst_req_d = (state_d == S_REQ);

    req_pc_d = req_pc_q;
    if (issue && !misaligned) req_pc_d = pc_in;

    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_adel_d  = out_adel_q;
    if (load_fetch) begin
      out_valid_d = 1'b1;
      out_pc_d    = req_pc_q;
      out_inst_d  = inst_rdata;
      out_adel_d  = 1'b0;
    end else if (load_adel) begin
      out_valid_d = 1'b1;
      out_pc_d    = pc_in;
      out_inst_d  = INST_NOP;
      out_adel_d  = 1'b1;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign inst_req  = inst_req_q;
  assign inst_addr = req_pc_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;
  assign out_adel  = out_adel_q;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch : self-checking bench for if_fetch.
// A PC-register model and a bus-slave model (programmable addr/data latency)
// surround the DUT. Every accepted address pushes the expected output onto a
// scoreboard queue; every out_valid&out_ready pops and compares. Table vectors
// check latency per wait-state mix; hand sequences cover reset, backpressure
// and flush in REQ/WAIT.
// ---------------------------------------------------------------------------
module tb_if_fetch;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_enable;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;

  if_fetch #(.INST_NOP(INST_NOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .pc_enable   (pc_enable),
    .flush       (flush),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_adel    (out_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    int          aw;
    int          dw;
    int          lat;
    logic        adel;
  } vec_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // commands and models
  logic        rst_cmd, flush_cmd, ready_cmd, bad_data;
  logic [31:0] redirect, pc_m, pend_addr;
  int          aw, dw, a_cnt, d_cnt;
  logic        pend;

  // snapshot of the cycle just stepped
  logic        s_pc_en, s_req, s_valid, s_adel;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hbfc0_0000) return 32'h2408_0001;
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // One clock cycle: drive at negedge, sample 1 time unit later, update models.
  task automatic step();
    exp_t e;
    @(negedge clk);
    rst_n        = !rst_cmd;
    pc_in        = pc_m;
    flush        = flush_cmd;
    out_ready    = ready_cmd;
    inst_addr_ok = rst_n && inst_req && (a_cnt == 0);
    inst_data_ok = rst_n && pend && (d_cnt == 0);
    inst_rdata   = inst_data_ok ? (bad_data ? 32'hdead_beef : mem(pend_addr)) : $urandom;
    #1;
    s_pc_en = pc_enable;
    s_req   = inst_req;
    s_addr  = inst_addr;
    s_valid = out_valid;
    s_pc    = out_pc;
    s_inst  = out_inst;
    s_adel  = out_adel;
    if (!rst_n) begin
      chk("pc_en_in_reset", 32'(pc_enable), 32'd0);
      sb_q.delete();
      pend  = 1'b0;
      a_cnt = aw;
    end else begin
      if (inst_req) begin
        chk("addr_stable", inst_addr, pc_in);
        chk("addr_aligned", 32'(inst_addr[1:0]), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual pc=%h inst=%h required=none", out_pc, out_inst);
        end else begin
          e = sb_q.pop_front();
          $display("txn pc=%h inst=%h adel=%0d", out_pc, out_inst, out_adel);
          chk("sb_pc", out_pc, e.pc);
          chk("sb_inst", out_inst, e.inst);
          chk("sb_adel", 32'(out_adel), 32'(e.adel));
        end
      end
      if (flush) begin
        sb_q.delete();
      end else if (pc_enable) begin
        e.pc   = pc_in;
        e.adel = |pc_in[1:0];
        e.inst = e.adel ? INST_NOP : mem(pc_in);
        sb_q.push_back(e);
      end
      if (pc_enable) pc_m = flush ? redirect : pc_m + 32'd4;
      // bus slave
      if (inst_data_ok) pend = 1'b0;
      else if (pend && d_cnt > 0) d_cnt--;
      if (inst_addr_ok) begin
        pend      = 1'b1;
        pend_addr = inst_addr;
        d_cnt     = dw;
      end
      if (!inst_req || inst_addr_ok) a_cnt = aw;
      else if (a_cnt > 0) a_cnt--;
    end
  endtask

  // Stall decode and wait for the DUT to park in IDLE with a held output.
  task automatic quiesce();
    ready_cmd = 1'b0;
    flush_cmd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (s_valid) return;
    end
    fail_timeout("quiesce");
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    flush_cmd = 1'b1;
    redirect  = pc;
    ready_cmd = 1'b0;
    step();
    chk("flush_pc_en", 32'(s_pc_en), 32'd1);
    flush_cmd = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  n;
    int  pe;
    logic hit;
    quiesce();
    aw = v.aw;
    dw = v.dw;
    redirect_to(v.pc);
    ready_cmd = 1'b1;
    n = 0; pe = 0; hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (v.adel) chk("adel_no_req", 32'(s_req), 32'd0);
      if (s_valid) begin
        hit = 1'b1;
        break;
      end
      pe += int'(s_pc_en);
      n++;
    end
    if (!hit) fail_timeout("vec_out_valid");
    else begin
      chk("vec_latency", 32'(n), 32'(v.lat));
      chk("vec_pc_en_pulses", 32'(pe), 32'd1);
      chk("vec_out_pc", s_pc, v.pc);
      chk("vec_out_adel", 32'(s_adel), 32'(v.adel));
    end
  endtask

  vec_t vecs[7];
  logic [31:0] ref_pc, ref_inst;

  initial begin
    vecs[0] = '{pc: 32'hbfc0_0100, aw: 0, dw: 0, lat: 3, adel: 1'b0};
    vecs[1] = '{pc: 32'hbfc0_0200, aw: 2, dw: 3, lat: 8, adel: 1'b0};
    vecs[2] = '{pc: 32'hbfc0_0300, aw: 1, dw: 0, lat: 4, adel: 1'b0};
    vecs[3] = '{pc: 32'hbfc0_0400, aw: 0, dw: 4, lat: 7, adel: 1'b0};
    vecs[4] = '{pc: 32'hbfc0_0002, aw: 0, dw: 0, lat: 1, adel: 1'b1};
    vecs[5] = '{pc: 32'hbfc0_0501, aw: 3, dw: 3, lat: 1, adel: 1'b1};
    vecs[6] = '{pc: 32'h0000_1000, aw: 5, dw: 1, lat: 9, adel: 1'b0};

    rst_n = 1'b0; pc_in = 32'h0; flush = 1'b0; inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0; inst_rdata = 32'h0; out_ready = 1'b0;
    rst_cmd = 1'b1; flush_cmd = 1'b1; ready_cmd = 1'b1; bad_data = 1'b0;
    redirect = 32'h0; pc_m = 32'hbfc0_0000; pend_addr = 32'h0;
    aw = 0; dw = 0; a_cnt = 0; d_cnt = 0; pend = 1'b0;

    // Reset (flush high must not leak onto pc_enable) and reset values
    step();
    flush_cmd = 1'b0;
    step();
    chk("rst_inst_req", 32'(s_req), 32'd0);
    chk("rst_inst_addr", s_addr, 32'd0);
    chk("rst_out_valid", 32'(s_valid), 32'd0);
    chk("rst_out_pc", s_pc, 32'd0);
    chk("rst_out_inst", s_inst, INST_NOP);
    chk("rst_out_adel", 32'(s_adel), 32'd0);

    // First fetch after release
    rst_cmd = 1'b0;
    step();
    chk("c0_req", 32'(s_req), 32'd0);
    chk("c0_pc_en", 32'(s_pc_en), 32'd0);
    step();
    chk("c1_req", 32'(s_req), 32'd1);
    chk("c1_addr", s_addr, 32'hbfc0_0000);
    chk("c1_pc_en", 32'(s_pc_en), 32'd1);
    step();
    chk("c2_pc_en", 32'(s_pc_en), 32'd0);
    chk("c2_valid", 32'(s_valid), 32'd0);
    step();
    chk("c3_valid", 32'(s_valid), 32'd1);
    chk("c3_out_pc", s_pc, 32'hbfc0_0000);
    chk("c3_out_inst", s_inst, 32'h2408_0001);

    // Decode backpressure
    quiesce();
    ref_pc   = s_pc;
    ref_inst = s_inst;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_no_req", 32'(s_req), 32'd0);
      chk("bp_valid_held", 32'(s_valid), 32'd1);
      chk("bp_pc_held", s_pc, ref_pc);
      chk("bp_inst_held", s_inst, ref_inst);
    end
    ready_cmd = 1'b1;
    step();
    step();
    chk("bp_req_after_ready", 32'(s_req), 32'd1);

    // Flush in WAIT, stale data arrives two cycles later
    quiesce();
    aw = 0; dw = 2;
    redirect_to(32'h0000_2000);
    ready_cmd = 1'b1;
    step();
    step();
    chk("fw_c1_addr", s_addr, 32'h0000_2000);
    bad_data  = 1'b1;
    flush_cmd = 1'b1;
    redirect  = 32'h0000_3000;
    step();
    chk("fw_pc_en", 32'(s_pc_en), 32'd1);
    flush_cmd = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      step();
      chk("fw_valid_low", 32'(s_valid), 32'd0);
      chk("fw_req_low", 32'(s_req), 32'd0);
    end
    bad_data = 1'b0;
    step();
    chk("fw_new_req", 32'(s_req), 32'd1);
    chk("fw_new_addr", s_addr, 32'h0000_3000);

    // Flush in REQ without addr_ok: request withdrawn
    quiesce();
    aw = 3; dw = 0;
    redirect_to(32'h0000_4000);
    ready_cmd = 1'b1;
    step();
    flush_cmd = 1'b1;
    redirect  = 32'h0000_5000;
    step();
    chk("fr_req_in_flush", 32'(s_req), 32'd1);
    chk("fr_pc_en", 32'(s_pc_en), 32'd1);
    flush_cmd = 1'b0;
    step();
    chk("fr_req_dropped", 32'(s_req), 32'd0);
    step();
    chk("fr_new_req", 32'(s_req), 32'd1);
    chk("fr_new_addr", s_addr, 32'h0000_5000);

    // Flush in REQ with addr_ok: DISCARD until the response returns
    quiesce();
    aw = 0; dw = 2;
    redirect_to(32'h0000_6000);
    ready_cmd = 1'b1;
    step();
    bad_data  = 1'b1;
    flush_cmd = 1'b1;
    redirect  = 32'h0000_7000;
    step();
    chk("fa_addr", s_addr, 32'h0000_6000);
    chk("fa_pc_en", 32'(s_pc_en), 32'd1);
    flush_cmd = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("fa_req_low", 32'(s_req), 32'd0);
      chk("fa_valid_low", 32'(s_valid), 32'd0);
    end
    bad_data = 1'b0;
    step();
    chk("fa_new_req", 32'(s_req), 32'd1);
    chk("fa_new_addr", s_addr, 32'h0000_7000);

    // Table-driven latency / misalignment vectors
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
